// File: rtl/fifo_packet_writer.sv
// Write-side controller for the shared packet FIFO: parses headers, fills slots, checks parity.
// Define FIFO_PKT_COUNT_EN to add saturating good/dropped packet counters.
module fifo_packet_writer #(
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned WIDTH     = 11,
  parameter int unsigned UWIDTH    = 8,
  parameter int unsigned PTR_SZ    = 2,
  parameter int unsigned PTR_IN_SZ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [UWIDTH-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 write_en,
  output logic [PTR_SZ-1:0]    waddr,
  output logic [PTR_IN_SZ-1:0] waddr_in,
  output logic [UWIDTH-1:0]    wdata,
  output logic                 pkt_commit,
  output logic [PTR_SZ-1:0]    pkt_slot,
  output logic [1:0]           pkt_dest,
  output logic [5:0]           pkt_len,
  input  logic                 slot_free,
  input  logic [PTR_SZ-1:0]    slot_free_addr,
  output logic                 err_parity,
  output logic                 err_hdr
`ifdef FIFO_PKT_COUNT_EN
  ,
  output logic [15:0]          pkt_ok_cnt,
  output logic [15:0]          pkt_drop_cnt
`endif
);

  localparam logic [5:0] MaxLen = 6'(WIDTH - 2);

  typedef enum logic [1:0] {StIdle, StPayload, StParity, StDiscard} state_e;

  state_e                 state_q, state_d;
  logic [DEPTH-1:0]       occ_q, occ_d;
  logic [PTR_SZ-1:0]      cur_slot_q;
  logic [1:0]             dest_q;
  logic [5:0]             len_q;
  logic [PTR_IN_SZ-1:0]   idx_q;
  logic [6:0]             cnt_q;
  logic [UWIDTH-1:0]      xor_q;

  logic                   accept;
  logic                   filling;
  logic [PTR_SZ-1:0]      alloc_idx;
  logic [1:0]             hdr_dest;
  logic [5:0]             hdr_len;
  logic                   hdr_ok;
  logic                   parity_ok;

  assign accept    = in_valid && in_ready;
  assign filling   = (state_q == StPayload) || (state_q == StParity);
  assign hdr_dest  = in_data[1:0];
  assign hdr_len   = in_data[7:2];
  assign hdr_ok    = (hdr_dest != 2'd0) && (hdr_len != 6'd0) && (hdr_len <= MaxLen);
  assign parity_ok = (in_data == xor_q);

  // Lowest-index free slot, taken from the pre-edge occupancy.
  always_comb begin
    alloc_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!occ_q[i]) alloc_idx = PTR_SZ'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    occ_d   = occ_q;
    // A release of the slot being filled is dropped; that slot is still owned here.
    if (slot_free && occ_q[slot_free_addr] && !(filling && (cur_slot_q == slot_free_addr))) begin
      occ_d[slot_free_addr] = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (hdr_ok) begin
            state_d          = StPayload;
            occ_d[alloc_idx] = 1'b1;
          end else begin
            state_d = StDiscard;
          end
        end
      end
      StPayload: begin
        if (accept && (6'(idx_q) == len_q)) state_d = StParity;
      end
      StParity: begin
        if (accept) begin
          state_d = StIdle;
          if (!parity_ok) occ_d[cur_slot_q] = 1'b0;
        end
      end
      StDiscard: begin
        if (accept && (cnt_q == 7'd1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      occ_q      <= '0;
      cur_slot_q <= '0;
      dest_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      xor_q      <= '0;
      in_ready   <= 1'b0;
      write_en   <= 1'b0;
      waddr      <= '0;
      waddr_in   <= '0;
      wdata      <= '0;
      pkt_commit <= 1'b0;
      pkt_slot   <= '0;
      pkt_dest   <= '0;
      pkt_len    <= '0;
      err_parity <= 1'b0;
      err_hdr    <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      in_ready   <= (state_d == StIdle) ? |(~occ_d) : 1'b1;
      write_en   <= 1'b0;
      pkt_commit <= 1'b0;
      err_parity <= 1'b0;
      err_hdr    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (hdr_ok) begin
              cur_slot_q <= alloc_idx;
              dest_q     <= hdr_dest;
              len_q      <= hdr_len;
              xor_q      <= in_data;
              idx_q      <= PTR_IN_SZ'(1);
              write_en   <= 1'b1;
              waddr      <= alloc_idx;
              waddr_in   <= '0;
              wdata      <= in_data;
            end else begin
              err_hdr <= 1'b1;
              cnt_q   <= {1'b0, hdr_len} + 7'd1;
            end
          end
        end
        StPayload: begin
          if (accept) begin
            write_en <= 1'b1;
            waddr    <= cur_slot_q;
            waddr_in <= idx_q;
            wdata    <= in_data;
            xor_q    <= xor_q ^ in_data;
            idx_q    <= idx_q + PTR_IN_SZ'(1);
          end
        end
        StParity: begin
          if (accept) begin
            if (parity_ok) begin
              pkt_commit <= 1'b1;
              pkt_slot   <= cur_slot_q;
              pkt_dest   <= dest_q;
              pkt_len    <= len_q;
            end else begin
              err_parity <= 1'b1;
            end
          end
        end
        StDiscard: begin
          if (accept) cnt_q <= cnt_q - 7'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_PKT_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_ok_cnt   <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      if (pkt_commit && (pkt_ok_cnt != 16'hFFFF)) pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
      if ((err_parity || err_hdr) && (pkt_drop_cnt != 16'hFFFF)) begin
        pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
      end
    end
  end
`else
  // No statistics counters in this build.
`endif

endmodule
